// File: rtl/stream_fanout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fanout_pkg
//  Description : Shared types, limits and helpers for the stream_fanout block:
//                wide channel-mask type, statistics counter ceiling and a
//                width-aware saturating increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_fanout_pkg;

    // Widest channel count and counter width the block is built for.
    localparam int MAX_CH     = 32;
    localparam int STAT_W_MAX = 32;

    // Channel mask wide enough for any legal NUM_CH; narrower masks are
    // zero-extended into it.
    typedef logic [MAX_CH-1:0] chan_mask_t;

    // All-ones value of the widest statistics counter.
    localparam logic [STAT_W_MAX-1:0] STAT_MAX = '1;

    // Saturating increment of a counter that is 'width' bits wide, carried
    // in a STAT_W_MAX-bit container. Holds at all-ones of the real width.
    function automatic logic [STAT_W_MAX-1:0] sat_inc(
        input logic [STAT_W_MAX-1:0] value,
        input int unsigned           width
    );
        logic [STAT_W_MAX-1:0] limit;
        if (width >= STAT_W_MAX) begin
            limit = STAT_MAX;
        end else begin
            limit = STAT_MAX >> (STAT_W_MAX - width);
        end
        if (value >= limit) begin
            return limit;
        end
        return value + 1'b1;
    endfunction

endpackage : stream_fanout_pkg
`default_nettype wire

// File: rtl/stream_fanout_chan.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fanout_chan
//  Description : One consumer channel of stream_fanout. Holds the per-channel
//                pending flag, detects the take handshake and, when
//                STREAM_FANOUT_STATS_EN is defined, keeps saturating counters
//                of takes and stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fanout_chan
    import stream_fanout_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              en,
    input  logic              out_ready,
    output logic              pending,
    output logic              take
`ifdef STREAM_FANOUT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_xfer,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    logic r_pending;

    // A take is a completed handshake on this channel.
    assign take    = r_pending & out_ready;
    assign pending = r_pending;

    // Pending flag: a new item loads the sampled enable, overriding any
    // take of the previous item in the same cycle; otherwise a take clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (accept) begin
            r_pending <= en;
        end else if (take) begin
            r_pending <= 1'b0;
        end
    end

`ifdef STREAM_FANOUT_STATS_EN
    logic [STAT_W-1:0] r_xfer;
    logic [STAT_W-1:0] r_stall;

    assign stat_xfer  = r_xfer;
    assign stat_stall = r_stall;

    // Saturating counters of takes and of cycles spent offered but not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer  <= '0;
            r_stall <= '0;
        end else begin
            if (take) begin
                r_xfer <= STAT_W'(sat_inc(STAT_W_MAX'(r_xfer), STAT_W));
            end
            if (r_pending && !out_ready) begin
                r_stall <= STAT_W'(sat_inc(STAT_W_MAX'(r_stall), STAT_W));
            end
        end
    end
`endif

endmodule : stream_fanout_chan
`default_nettype wire

// File: rtl/stream_fanout.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fanout
//  Description : Eager fork of one ready/valid source onto NUM_CH consumers.
//                A single shared output register holds the current item and
//                its sequence tag; the item retires once every channel that
//                was enabled at acceptance has taken it. 1-cycle latency,
//                1 item/cycle when all enabled consumers are ready.
//                Optional per-channel statistics: define STREAM_FANOUT_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fanout
    import stream_fanout_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int SEQ_W  = 8,
    parameter int STAT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic                     busy
`ifdef STREAM_FANOUT_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] stat_xfer,
    output logic [NUM_CH*STAT_W-1:0] stat_stall
`endif
);

    // Elaboration-time guards on the configuration.
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_chk_num_ch
        $error("stream_fanout: NUM_CH out of range");
    end
    if (STAT_W < 1 || STAT_W > STAT_W_MAX) begin : g_chk_stat_w
        $error("stream_fanout: STAT_W out of range");
    end

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_take;
    logic              w_accept;
    chan_mask_t        w_pending_ext;

    logic [DATA_W-1:0] r_data;
    logic [SEQ_W-1:0]  r_seq_out;
    logic [SEQ_W-1:0]  r_seq_next;

    // The source may advance only if every channel is either idle or taking
    // its copy this cycle; this is what lets a new item overwrite the
    // shared register without losing anything.
    assign in_ready  = &(~w_pending | out_ready);
    assign w_accept  = in_valid & in_ready;

    assign out_valid     = w_pending;
    assign out_data      = r_data;
    assign out_seq       = r_seq_out;
    assign w_pending_ext = chan_mask_t'(w_pending);
    assign busy          = |w_pending_ext;

    // Shared payload and sequence registers; loaded on every acceptance,
    // including items dropped by an all-zero enable mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_seq_out  <= '0;
            r_seq_next <= '0;
        end else if (w_accept) begin
            r_data     <= in_data;
            r_seq_out  <= r_seq_next;
            r_seq_next <= r_seq_next + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stream_fanout_chan #(
            .STAT_W     (STAT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .accept     (w_accept),
            .en         (ch_en[i]),
            .out_ready  (out_ready[i]),
            .pending    (w_pending[i]),
            .take       (w_take[i])
`ifdef STREAM_FANOUT_STATS_EN
            ,
            .stat_xfer  (stat_xfer[i*STAT_W +: STAT_W]),
            .stat_stall (stat_stall[i*STAT_W +: STAT_W])
`endif
        );
    end

    // Per-channel take strobes are consumed inside the channels (pending
    // clear and statistics); the top only needs the reduction below.
    logic w_any_take;
    assign w_any_take = |w_take;

    // Debug-visible registered flag: at least one channel took an item in
    // the previous cycle. Kept internal so the take strobes have a consumer
    // at the top level in every build.
    logic r_took;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_took <= 1'b0;
        end else begin
            r_took <= w_any_take;
        end
    end

    logic w_unused;
    assign w_unused = r_took;

endmodule : stream_fanout
`default_nettype wire
